// File: rtl/serial_pkg.sv
// Shared types and constants for the serial audio link.
// Used by the receive path and its synchroniser.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int   FRAME_DATA_BITS      = 8;
    localparam logic LINE_IDLE            = 1'b1;
    localparam int   DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/serial_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Both flops reset to RESET_VAL so an idle-high line reads idle.
module serial_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], async_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_o = sync_q[1];

endmodule

// File: rtl/serial_byte_receiver.sv
// Serial byte receiver: start detect, mid-bit sampling, LSB-first
// deserialiser and a single-entry valid/ready output buffer.
module serial_byte_receiver
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       CLOCK_50,
    input  logic       Reset_n,
    input  logic       Serial_In,
    output logic [7:0] Data_Out,
    output logic       Data_Valid,
    input  logic       Data_Ready,
    output logic       Frame_Error,
    output logic       Overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    // The timer expires at zero, so loads are one less than the period.
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX  = 3'(FRAME_DATA_BITS - 1);

    logic rx_s;

    rx_state_t  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic       done_q, done_d;
    logic       bad_q, bad_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;
    logic       expired;

    serial_rx_sync #(.RESET_VAL(LINE_IDLE)) u_sync (
        .clk    (CLOCK_50),
        .rst_n  (Reset_n),
        .async_i(Serial_In),
        .sync_o (rx_s)
    );

    assign expired = (timer_q == '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        bad_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_s != LINE_IDLE) begin
                    timer_d = HALF_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (!expired) begin
                    timer_d = timer_q - 1'b1;
                end else if (rx_s != LINE_IDLE) begin
                    timer_d = FULL_LOAD;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!expired) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    shift_d = {rx_s, shift_q[7:1]};
                    timer_d = FULL_LOAD;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (!expired) begin
                    timer_d = timer_q - 1'b1;
                end else if (rx_s == LINE_IDLE) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    bad_d   = 1'b1;
                    state_d = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rx_s == LINE_IDLE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion is acted on one cycle after the stop sample.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = bad_q;
        ovr_d   = 1'b0;
        if (done_q) begin
            if (!valid_q || Data_Ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && Data_Ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            bad_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            bad_q   <= bad_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign Data_Out    = data_q;
    assign Data_Valid  = valid_q;
    assign Frame_Error = ferr_q;
    assign Overrun     = ovr_q;

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Scoreboard bench for serial_byte_receiver: frames are driven on the
// line, expected events are queued with their cycle and checked by a monitor.
module tb_serial_byte_receiver;

    localparam int N = 16;
    localparam int L = 3 + N / 2 + 9 * N;
    localparam int K_BYTE = 0;
    localparam int K_FERR = 1;
    localparam int K_OVR  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rdy = 1'b1;
    logic [7:0] dout;
    logic       dvalid;
    logic       ferr;
    logic       ovr;

    serial_byte_receiver #(.CLKS_PER_BIT(N)) dut (
        .CLOCK_50   (clk),
        .Reset_n    (rst_n),
        .Serial_In  (rx),
        .Data_Out   (dout),
        .Data_Valid (dvalid),
        .Data_Ready (rdy),
        .Frame_Error(ferr),
        .Overrun    (ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic pend = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] d);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none",
                     kind, cyc);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == K_BYTE && e.kind == K_BYTE)
                chk("event_data", d, e.data);
            chk("event_cycle", cyc, e.at);
        end
    endtask

    // Reference: what a finished frame produces given the buffer state.
    function automatic int predict(input logic stop, input logic pending,
                                   input logic ready_at_done);
        if (!stop) return K_FERR;
        if (pending && !ready_at_done) return K_OVR;
        return K_BYTE;
    endfunction

    logic       prev_valid = 1'b0;
    logic       mon_accept;
    logic [7:0] held = '0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            mon_accept = prev_valid && rdy;
            if (dvalid && (!prev_valid || mon_accept)) begin
                expect_ev(K_BYTE, dout);
                held = dout;
            end else if (dvalid) begin
                chk("data_stable", dout, held);
            end
            if (ferr) expect_ev(K_FERR, 8'h00);
            if (ovr) expect_ev(K_OVR, 8'h00);
            prev_valid = dvalid;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic pulse);
        logic [9:0] bits;
        int e;
        int kind;
        bits = {stop, b, 1'b0};
        @(negedge clk);
        e = cyc + 1;
        kind = predict(stop, pend, pulse ? 1'b1 : rdy);
        q.push_back('{kind, b, e + L});
        if (kind == K_BYTE) pend = pulse || !rdy;
        for (int c = 0; c < 10 * N; c++) begin
            if (c > 0) @(negedge clk);
            rx = bits[c / N];
            if (pulse) begin
                if (cyc == e + L - 1) rdy = 1'b1;
                else if (cyc == e + L) rdy = 1'b0;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_valid"}, dvalid, 0);
        chk({tag, "_ferr"}, ferr, 0);
        chk({tag, "_ovr"}, ovr, 0);
    endtask

    initial begin
        int w;
        logic [7:0] b;
        logic       stop;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(5);

        send_frame(8'hA5, 1'b1, 1'b0);
        idle(20);

        repeat (4) begin
            @(negedge clk);
            rx = 1'b0;
        end
        idle(40);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(20);

        send_frame(8'hFF, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        idle(30);
        send_frame(8'h01, 1'b1, 1'b0);
        idle(20);

        rdy = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        idle(10);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(10);
        chk("overrun_keeps_old", dout, 8'h11);

        send_frame(8'h22, 1'b1, 1'b1);
        idle(10);
        chk("late_accept_data", dout, 8'h22);
        chk("late_accept_valid", dvalid, 1);

        @(negedge clk);
        rx = 1'b0;
        for (int c = 1; c < 5 * N + N / 2; c++) begin
            @(negedge clk);
            rx = 8'h5A >> ((c / N) - 1);
        end
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("midframe");
        rst_n = 1'b1;
        pend = 1'b0;
        rdy = 1'b1;
        idle(2 * N);
        check_reset_outputs("post_release");
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(20);

        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            send_frame(b, stop, 1'b0);
            if (stop) idle($urandom_range(0, 12));
            else idle($urandom_range(N, 2 * N));
        end

        idle(L);
        w = 0;
        while (q.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_byte_receiver.md
# serial_byte_receiver

Receive side of the serial audio link: recovers 8-bit bytes from the one-wire serial line driven by the transmit shift register. Synchronises the line into CLOCK_50, detects start bits, samples each bit at mid-period, deserialises LSB-first, and presents each byte on a valid/ready output towards the audio sample assembler. Flags framing errors and overruns.

## Interface
- CLKS_PER_BIT, default 434 — CLOCK_50 cycles per serial bit (115200 baud); legal range 4..65535
- CLOCK_50  input  1  system clock, all logic on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- Serial_In  input  1  asynchronous serial line; idle high
- Data_Out  output  8  received byte, LSB = first data bit on the line
- Data_Valid  output  1  Data_Out holds an unconsumed byte
- Data_Ready  input  1  consumer accepts Data_Out when high with Data_Valid
- Frame_Error  output  1  one-cycle pulse: stop bit sampled low
- Overrun  output  1  one-cycle pulse: byte completed while previous byte still unconsumed

## Operation
- Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Idle line is 1. Matches the transmit shift register's fill of 1s.
- Serial_In passes through a 2-flop synchroniser. Both flops reset to 1. All decisions use the synchronised value Rx_s.
- Bit timer: a down-counter of width $clog2(CLKS_PER_BIT). Bit index: a 3-bit counter.
- States:
  - IDLE: on Rx_s == 0, load timer with CLKS_PER_BIT/2 (integer division), go to START.
  - START: when the timer expires, sample Rx_s. If 0, reload CLKS_PER_BIT, clear the bit index, go to DATA. If 1, treat as a glitch and return to IDLE with no flags.
  - DATA: each expiry shifts Rx_s into bit [7] of the shift register, right-shifting the rest, so the first bit lands in [0]. After index 7, reload and go to STOP. Otherwise increment the index and reload.
  - STOP: on expiry, sample Rx_s.
    - If 1: byte complete, go to IDLE.
    - If 0: pulse Frame_Error, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until Rx_s == 1, then go to IDLE. This prevents a held-low break from re-triggering continuously.
- Output buffer: a single register with valid/ready semantics.
  - Byte complete with Data_Valid == 0, or with Data_Valid == 1 and Data_Ready == 1 in the same cycle: load Data_Out and set Data_Valid.
  - Byte complete with Data_Valid == 1 and Data_Ready == 0: pulse Overrun, drop the new byte, keep the old Data_Out.
  - Data_Ready == 1 with Data_Valid == 1 and no completion: clear Data_Valid. Data_Out keeps its value.
  - Data_Ready with Data_Valid == 0 has no effect.
- Data_Out is stable whenever Data_Valid is high and not being accepted.

## Timing
- Reset values: Data_Out = 8'h00, Data_Valid = 0, Frame_Error = 0, Overrun = 0, state IDLE, synchroniser = 2'b11, counters 0.
- Reset mid-frame returns immediately to IDLE and discards any partial byte. After release, reception restarts at the next falling edge of Rx_s.
- Let edge E be the first rising CLOCK_50 edge at which Serial_In is 0 (N = CLKS_PER_BIT).
  - Rx_s goes low 2 cycles after E.
  - Start sample at E+2+N/2.
  - Data bit k sample at E+2+N/2+(k+1)·N.
  - Stop sample at E+2+N/2+9·N.
- Data_Valid rises, or Frame_Error/Overrun pulses, on the edge after the stop sample. End-to-end latency from E to Data_Valid is 3+N/2+9·N cycles.
- A new start bit is accepted from the cycle after returning to IDLE. Back-to-back frames with zero idle time are supported.
- Flags are registered outputs, high for exactly one cycle. Frame_Error and Overrun are mutually exclusive per frame.

## Structure
- Shared package serial_pkg:
  - state enum rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE}
  - FRAME_DATA_BITS = 8
  - LINE_IDLE = 1'b1
  - DEFAULT_CLKS_PER_BIT = 434
- Sub-module serial_rx_sync: 2-flop synchroniser with reset value 1, reusable for other asynchronous inputs.
- Top level holds the FSM, bit timer, shift register and output buffer.

## Test plan
- Reset, then one frame of 8'hA5 with N=16, Data_Ready held 1. Expect Data_Out = 8'hA5, Data_Valid high for exactly 1 cycle at E+3+8+144, and no flags.
- Serial_In pulsed low for 4 cycles (N=16). Expect return to IDLE, no Data_Valid, no flags, and a following 8'h3C frame received correctly.
- Frame 8'hFF with the stop bit driven 0, then the line held low 100 cycles, then high. Expect one Frame_Error pulse, Data_Valid stays 0, no re-trigger while low, and the next 8'h01 frame received.
- Data_Ready = 0; send 8'h11 then 8'h22. Expect Data_Out stays 8'h11 with Data_Valid high, and a single Overrun pulse on completion of 8'h22.
- Data_Valid = 1 with 8'h11 pending, and Data_Ready asserted exactly in the completion cycle of 8'h22. Expect Data_Out = 8'h22 next cycle, Data_Valid remains 1, and no Overrun.
- Assert Reset_n low during data bit 4 of a frame. Expect all outputs at reset values and no partial byte; the next full frame 8'h5A is received correctly.
